axi_bram_slave: RTL

// - AXI4-Lite slave that serves the core's MMU bus (core_wrapper axi_* master ports) from on-chip block RAM.
// - Sits directly downstream of the core wrapper. Decodes one address window and supports byte strobes.
// - Returns DECERR for accesses outside the window. One outstanding transaction at a time.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/bram_sp_be.sv | 25 ++
 rtl/axi_bram_slave.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the BRAM slave state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_EXEC = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_MEM  = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;

  function automatic logic [1:0] access_resp(input logic hit);
    return hit ? RESP_OKAY : RESP_DECERR;
  endfunction

endpackage

// File: rtl/bram_sp_be.sv
// Single-port 32-bit RAM with per-byte write enables and a registered,
// read-first output; shaped so synthesis maps it onto block RAM.
module bram_sp_be #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_bram_slave.sv
// AXI4-Lite slave serving one address window from block RAM; one transaction
// in flight, writes win over reads, DECERR outside the window.
module axi_bram_slave
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORDS_LOG2 = 14
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  state_e                state_q, state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [WORDS_LOG2-1:0] idx_q, idx_d;
  logic                  hit_q, hit_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  rvalid_q, rvalid_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  idle;
  logic [31:0]           dec_addr;
  logic [31:0]           dec_off;
  logic                  dec_hit;
  logic [WORDS_LOG2-1:0] dec_idx;
  logic                  unused_byte_offset;
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [31:0]           ram_dout;

  // Readies are qualified by rstn so they drop the instant reset asserts.
  assign idle        = (state_q == ST_IDLE);
  assign axi_awready = rstn && idle && !aw_held_q;
  assign axi_wready  = rstn && idle && !w_held_q;
  assign axi_arready = rstn && idle && !aw_held_q && !w_held_q && !axi_awvalid && !axi_wvalid;

  // AR and AW can never hand-shake together, so one decoder serves both.
  assign dec_addr           = axi_arready ? axi_araddr : axi_awaddr;
  assign dec_off            = dec_addr - BASE_ADDR;
  assign dec_hit            = (dec_off[31:WORDS_LOG2+2] == '0);
  assign dec_idx            = dec_off[WORDS_LOG2+1:2];
  assign unused_byte_offset = ^dec_off[1:0];

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rvalid_d  = rvalid_q;
    bvalid_d  = bvalid_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    case (state_q)
      ST_IDLE: begin
        if (axi_awvalid && axi_awready) begin
          aw_held_d = 1'b1;
          idx_d     = dec_idx;
          hit_d     = dec_hit;
        end
        if (axi_wvalid && axi_wready) begin
          w_held_d = 1'b1;
          wdata_d  = axi_wdata;
          wstrb_d  = axi_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          state_d = ST_WR_EXEC;
        end else if (axi_arvalid && axi_arready) begin
          idx_d   = dec_idx;
          hit_d   = dec_hit;
          state_d = ST_RD_MEM;
        end
      end
      ST_WR_EXEC: begin
        bresp_d  = access_resp(hit_q);
        bvalid_d = 1'b1;
        state_d  = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (axi_bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_MEM: begin
        rresp_d  = access_resp(hit_q);
        rvalid_d = 1'b1;
        state_d  = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write strobes come straight from state_q, so a reset that lands before
  // the WR_EXEC edge cancels the RAM write.
  assign ram_en = (state_q == ST_WR_EXEC) || (state_q == ST_RD_MEM);
  assign ram_we = (state_q == ST_WR_EXEC && hit_q) ? wstrb_q : 4'b0000;

  bram_sp_be #(
    .ADDR_W (WORDS_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (idx_q),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  // RAM output only advances in RD_MEM/WR_EXEC, so it holds through RD_RESP.
  assign axi_rdata  = (state_q == ST_RD_RESP && hit_q) ? ram_dout : 32'h0;
  assign axi_rresp  = rresp_q;
  assign axi_rvalid = rvalid_q;
  assign axi_bresp  = bresp_q;
  assign axi_bvalid = bvalid_q;

endmodule
